// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: loads matrices A (N x K) and B (K x N) and feeds them
// skewed into an N x N systolic array. It clears the accumulators, primes the
// valids and streams for K+N steps. It then waits for the array to finish and
// captures the result.
// Optional build macro FEEDER_TIMEOUT_EN adds a DRAIN watchdog. When the
// array stays silent for TIMEOUT cycles, the watchdog pulses error and
// returns to IDLE.
// Every output is a register. Each output register is loaded with the value
// that belongs to the state being entered, so an output changes in the same
// cycle as the state it describes.
module systolic_skew_feeder #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int K       = 4,
  parameter int CW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*K*DW-1:0]     a_mat_flat,
  input  logic [K*N*DW-1:0]     b_mat_flat,
  output logic                  clr,
  output logic [N*DW-1:0]       a_left_flat,
  output logic [N-1:0]          a_v_row_flat,
  output logic [N*DW-1:0]       b_top_flat,
  output logic [N-1:0]          b_v_col_flat,
  input  logic                  array_done,
  input  logic [N*N*CW-1:0]     array_c_flat,
  output logic [N*N*CW-1:0]     c_out_flat,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    PRIME   = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4,
    CAPTURE = 3'd5
  } state_t;

  // The step counter only has to reach K+N-1.
  localparam int STEPS = K + N;
  localparam int TW    = $clog2(STEPS);

  state_t              state_reg, state_next;
  logic [TW-1:0]       t_reg, t_next;
  logic [N*K*DW-1:0]   a_lat_reg;
  logic [K*N*DW-1:0]   b_lat_reg;
  logic                capture_go;

  logic                clr_reg, clr_next;
  logic [N*DW-1:0]     a_left_reg, a_left_next;
  logic [N*DW-1:0]     b_top_reg, b_top_next;
  logic [N-1:0]        valid_reg, valid_next;
  logic [N*N*CW-1:0]   c_out_reg;
  logic                busy_reg, busy_next;
  logic                result_valid_reg;

`ifdef FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0]       wd_reg, wd_next;
  logic                error_reg, error_next;
`endif

  // Next-state logic: walk the job sequence and advance the step counter in STREAM.
  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    capture_go = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    wd_next    = wd_reg;
    error_next = 1'b0;
`endif
    case (state_reg)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = PRIME;
      PRIME: begin
        state_next = STREAM;
        t_next     = '0;
      end
      STREAM: begin
        if (t_reg == TW'(STEPS - 1)) begin
          state_next = DRAIN;
          t_next     = '0;
`ifdef FEEDER_TIMEOUT_EN
          wd_next    = '0;
`endif
        end else begin
          t_next = t_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (array_done) begin
          state_next = CAPTURE;
          capture_go = 1'b1;
`ifdef FEEDER_TIMEOUT_EN
        end else if (wd_reg == WW'(TIMEOUT - 1)) begin
          // The array never answered: abandon the job and keep the old result.
          state_next = IDLE;
          error_next = 1'b1;
          wd_next    = '0;
        end else begin
          wd_next = wd_reg + 1'b1;
`endif
        end
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values for the state being entered, including the skewed operand selection.
  always_comb begin
    clr_next    = (state_next == CLEAR);
    busy_next   = (state_next != IDLE);
    valid_next  = (state_next == PRIME || state_next == STREAM) ? '1 : '0;
    a_left_next = '0;
    b_top_next  = '0;
    if (state_next == STREAM) begin
      for (int i = 0; i < N; i++) begin
        // Row i lags row 0 by i steps and shows A[i][t-i] while that index is valid.
        if (int'(t_next) >= i && int'(t_next) < i + K)
          a_left_next[i*DW +: DW] = a_lat_reg[(i*K + int'(t_next) - i)*DW +: DW];
        // Column i lags column 0 by i steps and shows B[t-i][i] while that index is valid.
        if (int'(t_next) >= i && int'(t_next) < i + K)
          b_top_next[i*DW +: DW] = b_lat_reg[((int'(t_next) - i)*N + i)*DW +: DW];
      end
    end
  end

  // State, operand latches and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      t_reg            <= '0;
      a_lat_reg        <= '0;
      b_lat_reg        <= '0;
      clr_reg          <= 1'b0;
      a_left_reg       <= '0;
      b_top_reg        <= '0;
      valid_reg        <= '0;
      c_out_reg        <= '0;
      busy_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      wd_reg           <= '0;
      error_reg        <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      t_reg            <= t_next;
      clr_reg          <= clr_next;
      a_left_reg       <= a_left_next;
      b_top_reg        <= b_top_next;
      valid_reg        <= valid_next;
      busy_reg         <= busy_next;
      result_valid_reg <= capture_go;
`ifdef FEEDER_TIMEOUT_EN
      wd_reg           <= wd_next;
      error_reg        <= error_next;
`endif
      // Private copies keep the running job immune to input changes.
      if (state_reg == IDLE && start) begin
        a_lat_reg <= a_mat_flat;
        b_lat_reg <= b_mat_flat;
      end
      if (capture_go)
        c_out_reg <= array_c_flat;
    end
  end

  assign clr          = clr_reg;
  assign a_left_flat  = a_left_reg;
  assign b_top_flat   = b_top_reg;
  assign a_v_row_flat = valid_reg;
  assign b_v_col_flat = valid_reg;
  assign c_out_flat   = c_out_reg;
  assign busy         = busy_reg;
  assign result_valid = result_valid_reg;
`ifdef FEEDER_TIMEOUT_EN
  assign error        = error_reg;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder. It drives the feeder into a small
// behavioural output-stationary systolic array.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int K  = 4;
  localparam int CW = 16;
  localparam int TO = 64;

  logic                clk = 1'b0;
  logic                rst, start, array_done;
  logic [N*K*DW-1:0]   a_mat_flat;
  logic [K*N*DW-1:0]   b_mat_flat;
  logic                clr, busy, result_valid, error;
  logic [N*DW-1:0]     a_left_flat, b_top_flat;
  logic [N-1:0]        a_v_row_flat, b_v_col_flat;
  logic [N*N*CW-1:0]   array_c_flat, c_out_flat;

  int checks = 0;
  int failures = 0;
  int rv_cnt = 0;
  int drain_cnt = 0;
  logic done_en = 1'b1;
  logic err_seen = 1'b0;

  int a1 [4][4] = '{'{1,2,3,4}, '{5,6,7,8}, '{2,4,6,8}, '{1,3,5,7}};
  int b1 [4][4] = '{'{1,0,0,1}, '{0,1,0,1}, '{0,0,1,1}, '{1,1,1,2}};
  int c1 [4][4] = '{'{5,6,7,14}, '{13,14,15,34}, '{10,12,14,28}, '{8,10,12,23}};
  int a2 [4][4] = '{'{-1,2,0,1}, '{3,0,-2,0}, '{0,0,0,0}, '{1,1,1,1}};
  int bi [4][4] = '{'{1,0,0,0}, '{0,1,0,0}, '{0,0,1,0}, '{0,0,0,1}};
  int c2 [4][4] = '{'{-1,2,0,1}, '{3,0,-2,0}, '{0,0,0,0}, '{1,1,1,1}};

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .DW(DW), .K(K), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_mat_flat(a_mat_flat), .b_mat_flat(b_mat_flat),
    .clr(clr), .a_left_flat(a_left_flat), .a_v_row_flat(a_v_row_flat),
    .b_top_flat(b_top_flat), .b_v_col_flat(b_v_col_flat),
    .array_done(array_done), .array_c_flat(array_c_flat),
    .c_out_flat(c_out_flat), .busy(busy), .result_valid(result_valid),
    .error(error)
  );

  // Behavioural output-stationary array: operands hop one PE right/down per cycle.
  logic signed [DW-1:0] ah [N][N];
  logic signed [DW-1:0] bh [N][N];
  logic signed [CW-1:0] acc [N][N];
  logic signed [DW-1:0] pe_a, pe_b;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pe_a = (j == 0) ? a_left_flat[i*DW +: DW] : ah[i][j-1];
        pe_b = (i == 0) ? b_top_flat[j*DW +: DW] : bh[i-1][j];
        ah[i][j] <= pe_a;
        bh[i][j] <= pe_b;
        acc[i][j] <= clr ? '0 : acc[i][j] + CW'(pe_a) * CW'(pe_b);
      end
    end
  end

  always_comb begin
    array_c_flat = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        array_c_flat[(i*N+j)*CW +: CW] = acc[i][j];
  end

  // The array reports done a fixed number of cycles after the feeder goes quiet.
  always @(posedge clk) begin
    if (rst || !busy) drain_cnt <= 0;
    else if (!clr && a_v_row_flat == '0) drain_cnt <= drain_cnt + 1;
  end
  assign array_done = done_en && (drain_cnt >= 10);

  always @(negedge clk) begin
    if (result_valid) rv_cnt <= rv_cnt + 1;
    if (error) err_seen <= 1'b1;
  end

  function automatic logic [N*K*DW-1:0] pack_m(input int m [4][4]);
    logic [N*K*DW-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        r[(i*4+k)*DW +: DW] = DW'(m[i][k]);
    return r;
  endfunction

  function automatic logic [N*N*CW-1:0] pack_c(input int m [4][4]);
    logic [N*N*CW-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[(i*4+j)*CW +: CW] = CW'(m[i][j]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [N*N*CW-1:0] got,
                       input logic [N*N*CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!result_valid && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_result_seen"}, result_valid, 1'b1);
  endtask

  initial begin
    logic [N*N*CW-1:0] c_prev;
    int n;
    rst = 1'b1; start = 1'b0; a_mat_flat = '0; b_mat_flat = '0;
    tick(); tick();
    check("rst_clr", clr, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valids", {a_v_row_flat, b_v_col_flat}, '0);
    check("rst_data", {a_left_flat, b_top_flat}, '0);
    check("rst_cout", c_out_flat, '0);
    check("rst_rv_err", {result_valid, error}, 2'b00);
    rst = 1'b0;
    tick();

    // Job 1: skew, latching and end-to-end result.
    a_mat_flat = pack_m(a1); b_mat_flat = pack_m(b1); start = 1'b1;
    tick(); start = 1'b0;
    check("clear_clr", clr, 1'b1);
    check("clear_busy", busy, 1'b1);
    check("clear_valids", {a_v_row_flat, b_v_col_flat}, '0);
    tick();
    check("prime_clr", clr, 1'b0);
    check("prime_valids", {a_v_row_flat, b_v_col_flat}, 8'hFF);
    check("prime_data", {a_left_flat, b_top_flat}, '0);
    tick();
    check("t0_a_left", a_left_flat, 32'h00000001);
    check("t0_b_top", b_top_flat, 32'h00000001);
    // Ignored start plus input corruption mid-job.
    start = 1'b1; a_mat_flat = {N*K{8'h7F}}; b_mat_flat = {K*N{8'h55}};
    tick(); start = 1'b0;
    tick();
    tick();
    check("t3_a_left", a_left_flat, 32'h01040704);
    check("t3_b_top", b_top_flat, 32'h01000001);
    tick(); tick(); tick(); tick();
    check("t7_data", {a_left_flat, b_top_flat}, '0);
    check("t7_valids", {a_v_row_flat, b_v_col_flat}, 8'hFF);
    tick();
    check("drain_valids", {a_v_row_flat, b_v_col_flat}, '0);
    check("drain_busy", busy, 1'b1);
    wait_result("job1");
    check("job1_cout", c_out_flat, pack_c(c1));
    $display("job1 done c_out=%0h", c_out_flat);
    tick();
    check("job1_rv_once", rv_cnt, 1);
    check("job1_idle", {busy, result_valid}, 2'b00);

    // Job 2 back-to-back, killed by reset at STREAM t=2.
    a_mat_flat = pack_m(a2); b_mat_flat = pack_m(bi); start = 1'b1;
    tick(); start = 1'b0;
    check("b2b_clr", clr, 1'b1);
    check("b2b_cout_hold", c_out_flat, pack_c(c1));
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_outs", {clr, a_v_row_flat, b_v_col_flat, a_left_flat, b_top_flat}, '0);
    check("mid_rst_cout", c_out_flat, '0);
    rst = 1'b0;
    $display("job2 aborted by reset");

    // Job 3: fresh job after reset, signed operands.
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    wait_result("job3");
    check("job3_cout", c_out_flat, pack_c(c2));
    $display("job3 done c_out=%0h", c_out_flat);
    a_mat_flat = '0;
    tick(); tick(); tick();
    check("job3_cout_hold", c_out_flat, pack_c(c2));
    check("rv_count", rv_cnt, 2);

`ifdef FEEDER_TIMEOUT_EN
    // Watchdog: the array never answers.
    done_en = 1'b0;
    c_prev = c_out_flat;
    start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while (!(busy && !clr && a_v_row_flat == '0) && n < 30) begin
      tick();
      n++;
    end
    check("wd_drain_seen", busy && !clr && a_v_row_flat == '0, 1'b1);
    n = 0;
    while (!error && n < TO + 10) begin
      tick();
      n++;
    end
    check("wd_latency", n, TO);
    check("wd_busy", busy, 1'b0);
    check("wd_rv", result_valid, 1'b0);
    check("wd_cout", c_out_flat, c_prev);
    tick();
    check("wd_err_pulse", error, 1'b0);
    check("wd_rv_count", rv_cnt, 2);
    done_en = 1'b1;
    $display("watchdog job done n=%0d", n);
`else
    c_prev = '0;
    n = 0;
    check("no_error", err_seen, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
